line_delay_buffer: RTL and testbench



---
 rtl/ldb_pkg.sv | 14 +
 rtl/ldb_ram.sv | 26 ++
 rtl/line_delay_buffer.sv | 105 ++++++++++
 tb/tb_line_delay_buffer.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ldb_pkg.sv
// Shared types and width helpers for the line delay buffer.
package ldb_pkg;

   typedef enum logic [1:0] {
      EMPTY,
      FILLING,
      PRIMED
   } ldb_state_t;

   function automatic int ldb_addr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ldb_ram.sv
// Circular sample store: one write port, asynchronous read that returns old data.
module ldb_ram
   import ldb_pkg::*;
#(
   parameter int DW    = 4,
   parameter int DEPTH = 32,
   parameter int AW    = ldb_addr_w(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] wdata,
   output logic [DW-1:0] rdata
);

   (* ram_style="distributed" *)
   logic [DW-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem_q[addr] <= wdata;
   end

   // Read sees the pre-edge contents, so a same-address write never bypasses.
   assign rdata = mem_q[addr];

endmodule

// File: rtl/line_delay_buffer.sv
// Programmable multi-channel sample delay line with fill gating.
// Optional status outputs (primed, fill_level) under LDB_STATUS_EN.
module line_delay_buffer
   import ldb_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter int CHANNELS  = 1,
   parameter int MAX_DEPTH = 32,
   parameter int DEPTH_W   = $clog2(MAX_DEPTH + 1)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      cfg_load,
   input  logic [DEPTH_W-1:0]        cfg_depth,
   input  logic                      in_valid,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   output logic                      out_valid,
   output logic [CHANNELS*WIDTH-1:0] out_data
`ifdef LDB_STATUS_EN
   ,
   output logic                      primed,
   output logic [DEPTH_W-1:0]        fill_level
`endif
);

   localparam int DW = CHANNELS * WIDTH;
   localparam int AW = ldb_addr_w(MAX_DEPTH);
   localparam logic [DEPTH_W-1:0] DMAX = DEPTH_W'(MAX_DEPTH);
   localparam logic [DEPTH_W-1:0] ONE  = DEPTH_W'(1);

   ldb_state_t         state_q;
   logic [DEPTH_W-1:0] depth_q;
   logic [DEPTH_W-1:0] depth_d;
   logic [DEPTH_W-1:0] fill_q;
   logic [DEPTH_W-1:0] fill_d;
   logic [AW-1:0]      wptr_q;
   logic [AW-1:0]      wptr_d;
   logic               accept;
   logic               bypass;
   logic               ram_we;
   logic [DW-1:0]      ram_rdata;

   assign accept  = in_valid & ~cfg_load;
   assign bypass  = (depth_q == '0);
   assign ram_we  = accept & ~bypass;
   assign depth_d = (cfg_depth > DMAX) ? DMAX : cfg_depth;
   assign fill_d  = fill_q + ONE;
   assign wptr_d  = (DEPTH_W'(wptr_q) == depth_q - ONE) ? '0
                  : wptr_q + AW'(1);

   ldb_ram #(
      .DW    (DW),
      .DEPTH (MAX_DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .addr  (wptr_q),
      .wdata (in_data),
      .rdata (ram_rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= EMPTY;
         depth_q   <= DMAX;
         wptr_q    <= '0;
         fill_q    <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (cfg_load) begin
         depth_q   <= depth_d;
         wptr_q    <= '0;
         fill_q    <= '0;
         out_valid <= 1'b0;
         // Bypass has nothing to fill, so it is primed immediately.
         state_q   <= (depth_d == '0) ? PRIMED : EMPTY;
      end else begin
         out_valid <= 1'b0;
         if (accept) begin
            if (bypass) begin
               out_valid <= 1'b1;
               out_data  <= in_data;
            end else begin
               out_data  <= ram_rdata;
               out_valid <= (state_q == PRIMED);
               wptr_q    <= wptr_d;
               case (state_q)
                  EMPTY, FILLING: begin
                     fill_q  <= fill_d;
                     state_q <= (fill_d == depth_q) ? PRIMED : FILLING;
                  end
                  default: ;
               endcase
            end
         end
      end
   end

`ifdef LDB_STATUS_EN
   assign primed     = (state_q == PRIMED);
   assign fill_level = fill_q;
`endif

endmodule

// File: tb/tb_line_delay_buffer.sv
// Randomized bench for line_delay_buffer against a queue-based delay model.
module tb_line_delay_buffer;

   localparam int WIDTH     = 4;
   localparam int CHANNELS  = 2;
   localparam int MAX_DEPTH = 32;
   localparam int DEPTH_W   = $clog2(MAX_DEPTH + 1);
   localparam int DW        = WIDTH * CHANNELS;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               cfg_load = 1'b0;
   logic [DEPTH_W-1:0] cfg_depth = '0;
   logic               in_valid = 1'b0;
   logic [DW-1:0]      in_data = '0;
   logic               out_valid;
   logic [DW-1:0]      out_data;
`ifdef LDB_STATUS_EN
   logic               primed;
   logic [DEPTH_W-1:0] fill_level;
`endif

   int errors = 0;
   int checks = 0;

   int            mdepth;
   logic [DW-1:0] mq [$];
   bit            ev;
   logic [DW-1:0] ed;
   bit            known;

   line_delay_buffer #(
      .WIDTH     (WIDTH),
      .CHANNELS  (CHANNELS),
      .MAX_DEPTH (MAX_DEPTH),
      .DEPTH_W   (DEPTH_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cfg_load  (cfg_load),
      .cfg_depth (cfg_depth),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_data  (out_data)
`ifdef LDB_STATUS_EN
      ,
      .primed     (primed),
      .fill_level (fill_level)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic model_reset();
      mdepth = MAX_DEPTH;
      mq.delete();
      ev    = 1'b0;
      ed    = '0;
      known = 1'b1;
   endtask

   // Applies one cycle of stimulus and advances the reference model.
   task automatic drive(input bit ld, input int cd, input bit v,
                        input logic [DW-1:0] d);
      cfg_load  = ld;
      cfg_depth = DEPTH_W'(cd);
      in_valid  = v;
      in_data   = d;
      if (ld) begin
         mdepth = (cd > MAX_DEPTH) ? MAX_DEPTH : cd;
         mq.delete();
         ev = 1'b0;
      end else if (v) begin
         if (mdepth == 0) begin
            ev = 1'b1; ed = d; known = 1'b1;
         end else begin
            mq.push_back(d);
            if (mq.size() > mdepth) begin
               ev = 1'b1; ed = mq.pop_front(); known = 1'b1;
            end else begin
               ev = 1'b0; known = 1'b0;
            end
         end
      end else begin
         ev = 1'b0;
      end
      @(posedge clk);
      #1;
      cfg_load = 1'b0;
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #3;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_valid got=%0b exp=0", out_valid);
      end
      checks++;
      if (out_data !== '0) begin
         errors++;
         $display("FAIL reset_data got=%0h exp=0", out_data);
      end
`ifdef LDB_STATUS_EN
      checks++;
      if (primed !== 1'b0 || fill_level !== '0) begin
         errors++;
         $display("FAIL reset_status primed=%0b fill=%0d exp=0/0",
                  primed, fill_level);
      end
`endif
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
   endtask

   task automatic test_stream3();
      int first = 0;
      int nv = 0;
      drive(1'b1, 3, 1'b0, '0);
      for (int i = 1; i <= 8; i++) begin
         drive(1'b0, 0, 1'b1, {4'(i), 4'(i)});
         checks++;
         if (out_valid !== ev) begin
            errors++;
            $display("FAIL stream3_valid acc=%0d got=%0b exp=%0b",
                     i, out_valid, ev);
         end
         if (known) begin
            checks++;
            if (out_data !== ed) begin
               errors++;
               $display("FAIL stream3_data acc=%0d got=%0h exp=%0h",
                        i, out_data, ed);
            end
         end
         if (out_valid) begin
            nv++;
            if (first == 0) first = i;
         end
      end
      checks++;
      if (first != 4 || nv != 5) begin
         errors++;
         $display("FAIL stream3_first first=%0d n=%0d exp=4/5", first, nv);
      end
      drive(1'b0, 0, 1'b0, '0);
      checks++;
      if (out_valid !== 1'b0 || out_data !== 8'h55) begin
         errors++;
         $display("FAIL stream3_hold v=%0b d=%0h exp=0/55",
                  out_valid, out_data);
      end
   endtask

   task automatic test_toggle();
      drive(1'b1, 3, 1'b0, '0);
      for (int i = 0; i < 16; i++) begin
         drive(1'b0, 0, (i % 2) == 0, DW'($urandom));
         checks++;
         if (out_valid !== ev) begin
            errors++;
            $display("FAIL toggle_valid cyc=%0d got=%0b exp=%0b",
                     i, out_valid, ev);
         end
         if (known) begin
            checks++;
            if (out_data !== ed) begin
               errors++;
               $display("FAIL toggle_data cyc=%0d got=%0h exp=%0h",
                        i, out_data, ed);
            end
         end
      end
   endtask

   task automatic test_clamp();
      int first = 0;
      drive(1'b1, 40, 1'b0, '0);
      for (int i = 1; i <= 40; i++) begin
         drive(1'b0, 0, 1'b1, DW'($urandom));
         checks++;
         if (out_valid !== ev) begin
            errors++;
            $display("FAIL clamp_valid acc=%0d got=%0b exp=%0b",
                     i, out_valid, ev);
         end
         if (known) begin
            checks++;
            if (out_data !== ed) begin
               errors++;
               $display("FAIL clamp_data acc=%0d got=%0h exp=%0h",
                        i, out_data, ed);
            end
         end
         if (out_valid && first == 0) first = i;
      end
      checks++;
      if (first != 33) begin
         errors++;
         $display("FAIL clamp_first got=%0d exp=33", first);
      end
   endtask

   task automatic test_bypass();
      drive(1'b1, 0, 1'b0, '0);
      drive(1'b0, 0, 1'b1, 8'h55);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h55) begin
         errors++;
         $display("FAIL bypass_first v=%0b d=%0h exp=1/55",
                  out_valid, out_data);
      end
      for (int i = 0; i < 12; i++) begin
         drive(1'b0, 0, 1'($urandom), DW'($urandom));
         checks++;
         if (out_valid !== ev || out_data !== ed) begin
            errors++;
            $display("FAIL bypass_rand cyc=%0d v=%0b d=%0h exp=%0b/%0h",
                     i, out_valid, out_data, ev, ed);
         end
      end
   endtask

   task automatic test_reload();
      int first = 0;
      drive(1'b1, 4, 1'b0, '0);
      for (int i = 0; i < 8; i++) drive(1'b0, 0, 1'b1, DW'($urandom));
      drive(1'b1, 2, 1'b1, 8'hAA);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reload_drop got=%0b exp=0", out_valid);
      end
      for (int i = 1; i <= 6; i++) begin
         drive(1'b0, 0, 1'b1, DW'($urandom));
         checks++;
         if (out_valid !== ev) begin
            errors++;
            $display("FAIL reload_valid acc=%0d got=%0b exp=%0b",
                     i, out_valid, ev);
         end
         if (known) begin
            checks++;
            if (out_data !== ed) begin
               errors++;
               $display("FAIL reload_data acc=%0d got=%0h exp=%0h",
                        i, out_data, ed);
            end
         end
         if (out_valid && first == 0) first = i;
      end
      checks++;
      if (first != 3) begin
         errors++;
         $display("FAIL reload_first got=%0d exp=3", first);
      end
   endtask

   task automatic test_random();
      for (int r = 0; r < 4; r++) begin
         int d;
         d = (r == 0) ? 1 : int'($urandom_range(2, 7));
         drive(1'b1, d, 1'($urandom), DW'($urandom));
         for (int i = 0; i < 40; i++) begin
            drive(1'b0, 0, ($urandom % 4) != 0, DW'($urandom));
            checks++;
            if (out_valid !== ev) begin
               errors++;
               $display("FAIL rand_valid d=%0d cyc=%0d got=%0b exp=%0b",
                        d, i, out_valid, ev);
            end
            if (known) begin
               checks++;
               if (out_data !== ed) begin
                  errors++;
                  $display("FAIL rand_data d=%0d cyc=%0d got=%0h exp=%0h",
                           d, i, out_data, ed);
               end
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      int first = 0;
      drive(1'b1, 3, 1'b0, '0);
      for (int i = 0; i < 6; i++) drive(1'b0, 0, 1'b1, DW'($urandom | 1));
      rst_n = 1'b0;
      #2;
      checks++;
      if (out_valid !== 1'b0 || out_data !== '0) begin
         errors++;
         $display("FAIL midreset_out v=%0b d=%0h exp=0/0",
                  out_valid, out_data);
      end
`ifdef LDB_STATUS_EN
      checks++;
      if (primed !== 1'b0 || fill_level !== '0) begin
         errors++;
         $display("FAIL midreset_status primed=%0b fill=%0d exp=0/0",
                  primed, fill_level);
      end
`endif
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      for (int i = 1; i <= 34; i++) begin
         drive(1'b0, 0, 1'b1, DW'($urandom));
         checks++;
         if (out_valid !== ev) begin
            errors++;
            $display("FAIL midreset_valid acc=%0d got=%0b exp=%0b",
                     i, out_valid, ev);
         end
         if (known) begin
            checks++;
            if (out_data !== ed) begin
               errors++;
               $display("FAIL midreset_data acc=%0d got=%0h exp=%0h",
                        i, out_data, ed);
            end
         end
         if (out_valid && first == 0) first = i;
      end
      checks++;
      if (first != 33) begin
         errors++;
         $display("FAIL midreset_first got=%0d exp=33", first);
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_stream3();
      test_toggle();
      test_clamp();
      test_bypass();
      test_reload();
      test_random();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
